// File: rtl/ram_block_bridge.sv
// Block-to-word bridge: turns a cache block fill or write-back request into
// BLOCK_SIZE consecutive single-word SRAM accesses with a four-phase handshake.
module ram_block_bridge #(
   parameter int OFFSET_WIDTH = 3,
   parameter int ADDR_WIDTH   = 30,
   parameter int DATA_WIDTH   = 32,
   parameter int BLOCK_SIZE   = 1 << OFFSET_WIDTH,
   parameter int BLOCK_WIDTH  = DATA_WIDTH * BLOCK_SIZE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ram_en,
   input  logic                   ram_write,
   input  logic [ADDR_WIDTH-1:0]  ram_addr,
   input  logic [BLOCK_WIDTH-1:0] dc_data_wb,
   output logic                   ram_ready,
   output logic [BLOCK_WIDTH-1:0] block_from_ram,
   output logic                   sram_req,
   output logic                   sram_we,
   output logic [ADDR_WIDTH-1:0]  sram_addr,
   output logic [DATA_WIDTH-1:0]  sram_wdata,
   input  logic [DATA_WIDTH-1:0]  sram_rdata,
   input  logic                   sram_ack,
   output logic [1:0]             state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [OFFSET_WIDTH-1:0] LAST_CNT    = OFFSET_WIDTH'(BLOCK_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0]   OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_WIDTH) - 1);

   state_t                  state_q, state_d;
   logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [BLOCK_WIDTH-1:0]  wb_q, wb_d;
   logic [BLOCK_WIDTH-1:0]  block_q, block_d;
   logic                    ram_ready_q, ram_ready_d;
   logic                    sram_req_q, sram_req_d;
   logic                    sram_we_q, sram_we_d;
   logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
   logic [DATA_WIDTH-1:0]   sram_wdata_q, sram_wdata_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      wb_d    = wb_q;
      block_d = block_q;

      case (state_q)
         IDLE: begin
            if (ram_en) begin
               base_d  = ram_addr & ~OFFSET_MASK;
               wb_d    = dc_data_wb;
               cnt_d   = '0;
               state_d = ram_write ? WRITE : READ;
            end
         end
         READ, WRITE: begin
            if (sram_ack) begin
               if (state_q == READ) begin
                  block_d[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] = sram_rdata;
               end
               if (cnt_q == LAST_CNT) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (!ram_en) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // SRAM-side outputs are registered from the next state so the request,
      // address and data change together on the edge that accepts a word.
      ram_ready_d  = (state_d == DONE);
      sram_req_d   = (state_d == READ) || (state_d == WRITE);
      sram_we_d    = (state_d == WRITE);
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      if (sram_req_d) begin
         sram_addr_d  = base_d | ADDR_WIDTH'(cnt_d);
         sram_wdata_d = wb_d[int'(cnt_d) * DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         base_q       <= '0;
         wb_q         <= '0;
         block_q      <= '0;
         ram_ready_q  <= 1'b0;
         sram_req_q   <= 1'b0;
         sram_we_q    <= 1'b0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         base_q       <= base_d;
         wb_q         <= wb_d;
         block_q      <= block_d;
         ram_ready_q  <= ram_ready_d;
         sram_req_q   <= sram_req_d;
         sram_we_q    <= sram_we_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
      end
   end

   assign state          = state_q;
   assign ram_ready      = ram_ready_q;
   assign block_from_ram = block_q;
   assign sram_req       = sram_req_q;
   assign sram_we        = sram_we_q;
   assign sram_addr      = sram_addr_q;
   assign sram_wdata     = sram_wdata_q;

endmodule

// File: tb/tb_ram_block_bridge.sv
// Directed bench for ram_block_bridge: a tiny SRAM model with scripted ack
// stalls, plus hand-computed addresses, data and latencies.
module tb_ram_block_bridge;

   localparam int OW = 3;
   localparam int AW = 30;
   localparam int DW = 32;
   localparam int BS = 8;
   localparam int BW = DW * BS;

   logic          clk = 1'b0;
   logic          rst;
   logic          ram_en;
   logic          ram_write;
   logic [AW-1:0] ram_addr;
   logic [BW-1:0] dc_data_wb;
   logic          ram_ready;
   logic [BW-1:0] block_from_ram;
   logic          sram_req;
   logic          sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic [DW-1:0] sram_rdata;
   logic          sram_ack;
   logic [1:0]    state;

   logic [DW-1:0] rdata_off;

   always #5 clk = ~clk;

   // read word = offset + low address bits, so each word is distinguishable
   assign sram_rdata = rdata_off + DW'(sram_addr[OW-1:0]);

   ram_block_bridge #(
      .OFFSET_WIDTH(OW),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ram_en        (ram_en),
      .ram_write     (ram_write),
      .ram_addr      (ram_addr),
      .dc_data_wb    (dc_data_wb),
      .ram_ready     (ram_ready),
      .block_from_ram(block_from_ram),
      .sram_req      (sram_req),
      .sram_we       (sram_we),
      .sram_addr     (sram_addr),
      .sram_wdata    (sram_wdata),
      .sram_rdata    (sram_rdata),
      .sram_ack      (sram_ack),
      .state         (state)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [AW-1:0] acc_addr  [16];
   logic [DW-1:0] acc_wdata [16];
   logic          acc_we    [16];
   int            nacc;
   int            cycles;

   logic [BW-1:0] blk_a, blk_c, blk_e, wb_b, wb_d;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one transfer whose request was set up in the current cycle.
   task automatic do_xfer(input logic [AW-1:0] exp_base, input logic [BW-1:0] exp_wb,
                          input int stall_word, input int stall_len, input int drop_word);
      int stalled;
      stalled = 0;
      nacc    = 0;
      cycles  = 1;
      sram_ack = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step();
         cycles++;
         if (ram_ready) break;
         if (sram_req && int'(sram_addr[OW-1:0]) == stall_word && stalled < stall_len) begin
            sram_ack = 1'b0;
            stalled++;
            check_eq("stall_req", 256'(sram_req), 256'(1));
            check_eq("stall_addr", 256'(sram_addr), 256'(exp_base + AW'(stall_word)));
            check_eq("stall_wdata", 256'(sram_wdata), 256'(exp_wb[stall_word*DW +: DW]));
         end else begin
            sram_ack = 1'b1;
            if (sram_req) begin
               if (nacc < 16) begin
                  acc_addr[nacc]  = sram_addr;
                  acc_wdata[nacc] = sram_wdata;
                  acc_we[nacc]    = sram_we;
               end
               nacc++;
               if (int'(sram_addr[OW-1:0]) == drop_word) begin
                  ram_en     = 1'b0;
                  ram_addr   = '1;
                  ram_write  = ~ram_write;
                  dc_data_wb = ~dc_data_wb;
               end
            end
         end
      end
      check_eq("ready_seen", 256'(ram_ready), 256'(1));
   endtask

   task automatic verify_log(input logic [AW-1:0] exp_base, input logic exp_we,
                             input logic [BW-1:0] exp_wb, input logic chk_wdata);
      check_eq("n_words", 256'(nacc), 256'(BS));
      for (int i = 0; i < BS && i < nacc; i++) begin
         check_eq($sformatf("addr%0d", i), 256'(acc_addr[i]), 256'(exp_base + AW'(i)));
         check_eq($sformatf("we%0d", i), 256'(acc_we[i]), 256'(exp_we));
         if (chk_wdata)
            check_eq($sformatf("wdata%0d", i), 256'(acc_wdata[i]), 256'(exp_wb[i*DW +: DW]));
      end
   endtask

   initial begin
      for (int i = 0; i < BS; i++) begin
         blk_a[i*DW +: DW] = 32'hA0 + 32'(i);
         wb_b [i*DW +: DW] = 32'h11111111 * 32'(i);
         blk_c[i*DW +: DW] = 32'hC0 + 32'(i);
         wb_d [i*DW +: DW] = 32'h0D000000 + 32'(i * 3);
         blk_e[i*DW +: DW] = 32'h50 + 32'(i);
      end

      rst = 1'b0; ram_en = 1'b0; ram_write = 1'b0; ram_addr = '0;
      dc_data_wb = '0; sram_ack = 1'b0; rdata_off = '0;
      step(); step();
      check_eq("rst_state", 256'(state), 256'(0));
      check_eq("rst_ready", 256'(ram_ready), 256'(0));
      check_eq("rst_req", 256'(sram_req), 256'(0));
      check_eq("rst_addr", 256'(sram_addr), 256'(0));
      check_eq("rst_block", 256'(block_from_ram), 256'(0));
      rst = 1'b1;
      step();

      // fill from 0x13, ack tied high
      rdata_off = 32'hA0;
      ram_en = 1'b1; ram_write = 1'b0; ram_addr = 30'h13; dc_data_wb = wb_d;
      do_xfer(30'h10, wb_d, -1, 0, -1);
      check_eq("fill_latency", 256'(cycles), 256'(10));
      verify_log(30'h10, 1'b0, wb_d, 1'b1);
      check_eq("fill_block", 256'(block_from_ram), 256'(blk_a));
      check_eq("fill_done_req", 256'(sram_req), 256'(0));

      // ram_en held after ready: stay in DONE
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq($sformatf("hold_state%0d", i), 256'(state), 256'(3));
         check_eq($sformatf("hold_ready%0d", i), 256'(ram_ready), 256'(1));
         check_eq($sformatf("hold_req%0d", i), 256'(sram_req), 256'(0));
      end
      ram_en = 1'b0;
      step();
      check_eq("drop_state", 256'(state), 256'(0));
      check_eq("drop_ready", 256'(ram_ready), 256'(0));

      // immediate write-back to 0x28
      ram_en = 1'b1; ram_write = 1'b1; ram_addr = 30'h28; dc_data_wb = wb_b;
      do_xfer(30'h28, wb_b, -1, 0, -1);
      check_eq("wb_latency", 256'(cycles), 256'(10));
      verify_log(30'h28, 1'b1, wb_b, 1'b1);
      check_eq("wb_block_kept", 256'(block_from_ram), 256'(blk_a));
      ram_en = 1'b0;
      step();
      check_eq("wb_idle", 256'(state), 256'(0));

      // fill from 0x5B with word 4 stalled three cycles
      rdata_off = 32'hC0;
      ram_en = 1'b1; ram_write = 1'b0; ram_addr = 30'h5B; dc_data_wb = wb_d;
      do_xfer(30'h58, wb_d, 4, 3, -1);
      check_eq("stall_latency", 256'(cycles), 256'(13));
      verify_log(30'h58, 1'b0, wb_d, 1'b1);
      check_eq("stall_block", 256'(block_from_ram), 256'(blk_c));
      ram_en = 1'b0;
      step();

      // write-back to 0x6C, request dropped and inputs scrambled at word 2
      ram_en = 1'b1; ram_write = 1'b1; ram_addr = 30'h6C; dc_data_wb = wb_d;
      do_xfer(30'h68, wb_d, -1, 0, 2);
      check_eq("dropwr_latency", 256'(cycles), 256'(10));
      verify_log(30'h68, 1'b1, wb_d, 1'b1);
      check_eq("dropwr_block_kept", 256'(block_from_ram), 256'(blk_c));
      step();
      check_eq("dropwr_idle", 256'(state), 256'(0));
      check_eq("dropwr_ready_low", 256'(ram_ready), 256'(0));

      // reset during a fill, after word 3 has been acknowledged
      rdata_off = 32'hE0;
      ram_en = 1'b1; ram_write = 1'b0; ram_addr = 30'h80; sram_ack = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check_eq("pre_rst_addr", 256'(sram_addr), 256'(30'h84));
      #2 rst = 1'b0;
      #1;
      check_eq("arst_state", 256'(state), 256'(0));
      check_eq("arst_req", 256'(sram_req), 256'(0));
      check_eq("arst_we", 256'(sram_we), 256'(0));
      check_eq("arst_addr", 256'(sram_addr), 256'(0));
      check_eq("arst_ready", 256'(ram_ready), 256'(0));
      check_eq("arst_block", 256'(block_from_ram), 256'(0));
      step();
      ram_en = 1'b0;
      step();
      check_eq("arst_hold_req", 256'(sram_req), 256'(0));
      rst = 1'b1;
      step();
      check_eq("post_rst_req", 256'(sram_req), 256'(0));
      check_eq("post_rst_state", 256'(state), 256'(0));

      rdata_off = 32'h50;
      ram_en = 1'b1; ram_write = 1'b0; ram_addr = 30'h40;
      do_xfer(30'h40, wb_d, -1, 0, -1);
      check_eq("refill_latency", 256'(cycles), 256'(10));
      verify_log(30'h40, 1'b0, wb_d, 1'b0);
      check_eq("refill_block", 256'(block_from_ram), 256'(blk_e));
      ram_en = 1'b0;
      step();
      check_eq("refill_idle", 256'(state), 256'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_block_bridge.md
RAM_BLOCK_BRIDGE -- requirements
Module: ram_block_bridge

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- OFFSET_WIDTH, 3, word-offset bits within a block.
- ADDR_WIDTH, 30, word-address width.
- DATA_WIDTH, 32, word width.
- BLOCK_SIZE, 1<<OFFSET_WIDTH, words per block.
- BLOCK_WIDTH, DATA_WIDTH*BLOCK_SIZE, block width.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning); one clock, reset asynchronous active-low:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- ram_en, in, 1, block request from cache manager; held high until ram_ready.
- ram_write, in, 1, 1 = block write-back, 0 = block fill.
- ram_addr, in, ADDR_WIDTH, word address of the request.
- dc_data_wb, in, BLOCK_WIDTH, block to write back.
- ram_ready, out, 1, block transfer complete.
- block_from_ram, out, BLOCK_WIDTH, filled block.
- sram_req, out, 1, word access request.
- sram_we, out, 1, word write enable.
- sram_addr, out, ADDR_WIDTH, word address.
- sram_wdata, out, DATA_WIDTH, write word.
- sram_rdata, in, DATA_WIDTH, read word, valid with sram_ack.
- sram_ack, in, 1, word access accepted/complete.
- state, out, 2, debug: current FSM state.

Function
REQ-003 FSM states SHALL be IDLE=0, READ=1, WRITE=2, DONE=3, driven on state.
REQ-004 In IDLE with ram_en=1, the block SHALL latch base = {ram_addr[ADDR_WIDTH-1:OFFSET_WIDTH], zeros}, latch ram_write and dc_data_wb, clear counter cnt, and enter WRITE if ram_write=1, else READ.
REQ-005 In READ/WRITE, the block SHALL present sram_req=1, sram_addr=base|cnt and sram_we=(state==WRITE); sram_wdata SHALL equal latched word cnt, i.e. bits [DATA_WIDTH*cnt +: DATA_WIDTH].
REQ-006 sram_req and its address/data SHALL be held stable until sram_ack=1; ack is sampled on the rising edge and MAY arrive in the first request cycle.
REQ-007 On ack in READ, sram_rdata SHALL be stored into block_from_ram word cnt; other words SHALL be unchanged.
REQ-008 On ack with cnt<BLOCK_SIZE-1, cnt SHALL increment; on ack with cnt=BLOCK_SIZE-1, the FSM SHALL enter DONE and sram_req SHALL drop on the same edge.
REQ-009 Word order SHALL be ascending from base; the counter SHALL NOT wrap within a transfer.
REQ-010 In DONE, ram_ready SHALL be 1; the FSM SHALL stay in DONE while ram_en=1 and return to IDLE on the first edge with ram_en=0. This is a four-phase handshake and prevents retriggering.
REQ-011 ram_en deassertion or ram_addr/ram_write/dc_data_wb changes during READ/WRITE SHALL be ignored; the transfer completes on latched values.
REQ-012 block_from_ram SHALL hold the last filled block until the next READ overwrites it; WRITE transfers SHALL NOT modify it.
REQ-013 Minimum latency with sram_ack tied high SHALL be 1 (IDLE) + BLOCK_SIZE + 1 (DONE) cycles from ram_en to ram_ready, i.e. ram_ready in cycle 10 for BLOCK_SIZE=8.
REQ-014 sram_req SHALL be 0 in IDLE and DONE; at most one word access SHALL be outstanding.

Reset
REQ-015 rst=0 SHALL asynchronously force state=IDLE, cnt=0, ram_ready=0, sram_req=0, sram_we=0, sram_addr=0, sram_wdata=0 and block_from_ram=0.
REQ-016 Reset asserted mid-transfer SHALL abort the transfer with no further sram_req; after release, the block SHALL accept a new request from IDLE.

Verification
REQ-017 Fill, ack tied 1: ram_en=1, ram_write=0, ram_addr=0x0000_0013 -> sram_addr 0x10..0x17 on consecutive cycles, sram_we=0; rdata=0xA0+i -> block_from_ram word i=0xA0+i, ram_ready high 10 cycles after request.
REQ-018 Write-back: ram_write=1, ram_addr=0x28, dc_data_wb words 0x11111111*i -> eight writes to 0x28..0x2F with matching wdata, sram_we=1, block_from_ram unchanged.
REQ-019 Stalled ack: ack delayed 3 cycles on word 4 only -> sram_addr/wdata stable for those cycles, no skipped or duplicated word, ready one cycle after the final ack.
REQ-020 Handshake: hold ram_en=1 for 5 cycles after ram_ready -> remain in DONE, no second transfer; drop ram_en -> IDLE next edge; immediate new request -> normal start.
REQ-021 Reset mid-fill: rst=0 after word 3 ack -> all outputs 0 asynchronously, state=0; after release a new fill to 0x40 completes correctly.
REQ-022 ram_en dropped mid-write at word 2 -> all 8 words still written, then ram_ready=1 for 1 cycle before return to IDLE.
